// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low pattern table (bit0=a .. bit6=g),
// reader FSM states and a digit-to-pattern helper used by the display driver.
package seg7_pkg;

    // Active-low patterns, g..a ordering (0 = segment lit)
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Width of the stability counter; holds STABLE_CYCLES up to 255
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        PEND  = 2'd1,
        DONE  = 2'd2
    } seg7_state_t;

    // Forward table: hex digit to active-low pattern (driver side)
    function automatic logic [6:0] seg7_encode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0:    p = SEG_0;
            4'h1:    p = SEG_1;
            4'h2:    p = SEG_2;
            4'h3:    p = SEG_3;
            4'h4:    p = SEG_4;
            4'h5:    p = SEG_5;
            4'h6:    p = SEG_6;
            4'h7:    p = SEG_7;
            4'h8:    p = SEG_8;
            4'h9:    p = SEG_9;
            4'hA:    p = SEG_A;
            4'hB:    p = SEG_B;
            4'hC:    p = SEG_C;
            4'hD:    p = SEG_D;
            4'hE:    p = SEG_E;
            default: p = SEG_F;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_lookup.sv
// Combinational inverse table: active-low pattern to hex digit, with
// separate flags for the all-off pattern and for unknown patterns.
module seg7_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       blank_o,
    output logic       invalid_o
);

    // Exact-match decode; anything outside the table is flagged invalid
    always_comb begin
        digit_o   = 4'h0;
        blank_o   = 1'b0;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_0:     digit_o = 4'h0;
            SEG_1:     digit_o = 4'h1;
            SEG_2:     digit_o = 4'h2;
            SEG_3:     digit_o = 4'h3;
            SEG_4:     digit_o = 4'h4;
            SEG_5:     digit_o = 4'h5;
            SEG_6:     digit_o = 4'h6;
            SEG_7:     digit_o = 4'h7;
            SEG_8:     digit_o = 4'h8;
            SEG_9:     digit_o = 4'h9;
            SEG_A:     digit_o = 4'hA;
            SEG_B:     digit_o = 4'hB;
            SEG_C:     digit_o = 4'hC;
            SEG_D:     digit_o = 4'hD;
            SEG_E:     digit_o = 4'hE;
            SEG_F:     digit_o = 4'hF;
            SEG_BLANK: blank_o = 1'b1;
            default:   invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Samples an active-low 7-segment bus, waits for STABLE_CYCLES identical
// samples, decodes it once and offers the result on a valid/ready port.
// A result is reported once per stable pattern; changes while a result is
// waiting set a sticky overrun flag but never replace the pending result.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] digit,
    output logic       blank,
    output logic       invalid,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYCLES - 1);

    seg7_state_t      state_q;
    logic [6:0]       seg_q;
    logic [6:0]       pat_l_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_valid_q;
    logic [3:0]       digit_q;
    logic             blank_q;
    logic             invalid_q;
    logic             overrun_q;

    logic             seg_same;
    logic             count_done;
    logic [3:0]       dec_digit;
    logic             dec_blank;
    logic             dec_invalid;

    // Saturating increment: the counter parks at STABLE_CYCLES
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= STABLE_MAX) begin
            return STABLE_MAX;
        end
        return c + CNT_W'(1);
    endfunction

    // Decoder only ever sees the registered sample
    seg7_lookup u_lookup (
        .seg_i     (seg_q),
        .digit_o   (dec_digit),
        .blank_o   (dec_blank),
        .invalid_o (dec_invalid)
    );

    // Change detection against the incoming sample: seg_q keeps its value
    // across this edge only when seg equals it. The count completes on the
    // edge that delivers the STABLE_CYCLES-th identical sample, so a change
    // arriving on that same edge cancels the report.
    always_comb begin
        seg_same   = (seg == seg_q);
        cnt_d      = seg_same ? sat_inc(cnt_q) : '0;
        count_done = seg_same && (cnt_q >= STABLE_M1);
    end

    // Sampling register, stability counter, FSM and registered handshake
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= TRACK;
            seg_q       <= SEG_BLANK;
            pat_l_q     <= SEG_BLANK;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            digit_q     <= 4'h0;
            blank_q     <= 1'b0;
            invalid_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            seg_q <= seg;
            case (state_q)
                TRACK: begin
                    cnt_q <= cnt_d;
                    if (count_done) begin
                        pat_l_q     <= seg_q;
                        digit_q     <= dec_digit;
                        blank_q     <= dec_blank;
                        invalid_q   <= dec_invalid;
                        out_valid_q <= 1'b1;
                        state_q     <= PEND;
                    end
                end
                PEND: begin
                    cnt_q <= cnt_d;
                    if (!seg_same) begin
                        overrun_q <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        // Pattern still the reported one: suppress a repeat.
                        if (seg_q == pat_l_q && seg_same) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= TRACK;
                            cnt_q   <= '0;
                        end
                    end
                end
                DONE: begin
                    // seg_q equals pat_l here; any incoming change re-arms
                    cnt_q <= '0;
                    if (!seg_same) begin
                        state_q <= TRACK;
                    end
                end
                default: begin
                    state_q     <= TRACK;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign digit     = digit_q;
    assign blank     = blank_q;
    assign invalid   = invalid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with STABLE_CYCLES=4. Expected results are
// queued when a pattern is driven and compared when a handshake occurs.
module tb_seg7_reader;
    import seg7_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [6:0] seg;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] digit;
    logic       blank;
    logic       invalid;
    logic       overrun;

    int         n_vec = 0;
    int         n_err = 0;
    logic [5:0] sb_q[$];

    always #10 CLOCK_50 = ~CLOCK_50;

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .seg       (seg),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .digit     (digit),
        .blank     (blank),
        .invalid   (invalid),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {digit, blank, invalid}
    task automatic push(input logic [3:0] d, input logic b, input logic inv);
        sb_q.push_back({d, b, inv});
    endtask

    // One clock: handshake check at the falling edge, return 1 after rising edge
    task automatic tick();
        logic [5:0] e;
        @(negedge CLOCK_50);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_entry_for_result", {26'd0, digit, blank, invalid}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_result", {26'd0, digit, blank, invalid}, {26'd0, e});
            end
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !out_valid; i++) tick();
        chk("valid_within_bound", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        reset = 1'b1; seg = SEG_BLANK; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid",   {31'd0, out_valid}, 32'd0);
        chk("rst_digit",   {28'd0, digit},     32'd0);
        chk("rst_blank",   {31'd0, blank},     32'd0);
        chk("rst_invalid", {31'd0, invalid},   32'd0);
        chk("rst_overrun", {31'd0, overrun},   32'd0);

        // Digit 1 held: valid at edge 5 after release, single pulse
        seg = SEG_1;
        tick();
        reset = 1'b0;
        push(4'h1, 1'b0, 1'b0);
        repeat (4) tick();
        chk("t1_not_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1_valid_edge5", {31'd0, out_valid}, 32'd1);
        chk("t1_digit", {28'd0, digit}, 32'd1);
        chk("t1_flags", {30'd0, blank, invalid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t1_no_repeat", {31'd0, out_valid}, 32'd0);
        end

        // Alternating 2/3 every 2 cycles: nothing reported, then 3 settles
        for (int i = 0; i < 10; i++) begin
            seg = (i % 2 == 1) ? SEG_3 : SEG_2;
            tick();
            chk("t2_alt_quiet", {31'd0, out_valid}, 32'd0);
            tick();
            chk("t2_alt_quiet", {31'd0, out_valid}, 32'd0);
        end
        push(4'h3, 1'b0, 1'b0);
        tick(); tick();
        chk("t2_not_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_digit", {28'd0, digit}, 32'd3);
        tick();
        chk("t2_accepted", {31'd0, out_valid}, 32'd0);

        // F held without ready, then overrun by 0, then accept
        out_ready = 1'b0;
        seg = SEG_F;
        push(4'hF, 1'b0, 1'b0);
        repeat (4) tick();
        chk("t3_not_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t3_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_digit", {28'd0, digit}, 32'hF);
        chk("t3_no_overrun_yet", {31'd0, overrun}, 32'd0);
        seg = SEG_0;
        push(4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_digit", {28'd0, digit}, 32'hF);
        end
        chk("t3_overrun", {31'd0, overrun}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t3_accept", {31'd0, out_valid}, 32'd0);
        repeat (3) tick();
        chk("t3_zero_not_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t3_zero_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_zero_digit", {28'd0, digit}, 32'd0);
        tick();
        chk("t3_overrun_sticky", {31'd0, overrun}, 32'd1);

        // Unknown pattern, then all-off
        seg = 7'b0101010;
        push(4'h0, 1'b0, 1'b1);
        wait_valid(10);
        chk("t4_invalid", {31'd0, invalid}, 32'd1);
        chk("t4_inv_digit", {28'd0, digit}, 32'd0);
        tick();
        seg = SEG_BLANK;
        push(4'h0, 1'b1, 1'b0);
        wait_valid(10);
        chk("t4_blank", {31'd0, blank}, 32'd1);
        chk("t4_blank_invalid", {31'd0, invalid}, 32'd0);
        tick();

        // Change on the edge the count would complete: change wins
        seg = SEG_7;
        repeat (4) tick();
        chk("t5_quiet", {31'd0, out_valid}, 32'd0);
        seg = SEG_E;
        push(4'hE, 1'b0, 1'b0);
        tick();
        chk("t5_change_wins", {31'd0, out_valid}, 32'd0);
        repeat (3) tick();
        chk("t5_e_not_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t5_e_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_e_digit", {28'd0, digit}, 32'hE);
        tick();

        // 8 reported, one-cycle blank glitch, 8 reported again
        seg = SEG_8;
        push(4'h8, 1'b0, 1'b0);
        wait_valid(10);
        chk("t6_first8", {28'd0, digit}, 32'h8);
        tick();
        tick();
        chk("t6_done_quiet", {31'd0, out_valid}, 32'd0);
        seg = SEG_BLANK;
        tick();
        seg = SEG_8;
        push(4'h8, 1'b0, 1'b0);
        tick();
        chk("t6_glitch_quiet", {31'd0, out_valid}, 32'd0);
        repeat (3) tick();
        chk("t6_not_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t6_second8", {31'd0, out_valid}, 32'd1);
        chk("t6_second8_digit", {28'd0, digit}, 32'h8);
        tick();

        // Reset while pending drops result and overrun; full re-detection
        out_ready = 1'b0;
        seg = SEG_5;
        push(4'h5, 1'b0, 1'b0);
        wait_valid(10);
        chk("t7_pending_digit", {28'd0, digit}, 32'h5);
        reset = 1'b1;
        tick();
        chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_rst_overrun", {31'd0, overrun}, 32'd0);
        void'(sb_q.pop_front());
        reset = 1'b0;
        out_ready = 1'b1;
        push(4'h5, 1'b0, 1'b0);
        repeat (4) tick();
        chk("t7_not_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t7_valid", {31'd0, out_valid}, 32'd1);
        chk("t7_digit", {28'd0, digit}, 32'h5);
        tick();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
